si_div_16b_seq: RTL and testbench

- Iterative signed divider, radix-2 restoring, one quotient bit per clock.
- Inverse companion of the signed 8-bit multiplier path: divides a 16-bit signed product-width value by an 8-bit signed operand.
- Returns a truncated quotient and a remainder.
- Sits in the arithmetic datapath behind valid/ready handshakes on input and output.

---
 rtl/si_div_pkg.sv | 22 ++
 rtl/si_div_step.sv | 29 ++
 rtl/si_div_16b_seq.sv | 149 ++++++++++++++
 tb/tb_si_div_16b_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/si_div_pkg.sv
// si_div_pkg: shared definitions for the iterative signed divider.
//   - default operand widths (DW_DEF dividend/quotient, SW_DEF divisor/remainder)
//   - iteration counter width for the default dividend width
//   - quotient saturation constants used for divide-by-zero and overflow
//   - FSM state encoding
package si_div_pkg;

  localparam int DW_DEF = 16;
  localparam int SW_DEF = 8;
  localparam int CNT_W  = $clog2(DW_DEF);

  // Most positive / most negative quotient at the default width.
  localparam logic [DW_DEF-1:0] QMAX = {1'b0, {(DW_DEF-1){1'b1}}};
  localparam logic [DW_DEF-1:0] QMIN = {1'b1, {(DW_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/si_div_step.sv
// si_div_step: one radix-2 restoring division step (purely combinational).
//   pr      : current partial remainder magnitude (SW+1 bits, always < |dvs|)
//   din     : next dividend magnitude bit, MSB first
//   dvs_mag : divisor magnitude (SW bits, non-zero)
//   pr_nxt  : partial remainder after the step
//   qbit    : quotient bit produced by the step
module si_div_step #(
  parameter int SW = 8
) (
  input  logic [SW:0]   pr,
  input  logic          din,
  input  logic [SW-1:0] dvs_mag,
  output logic [SW:0]   pr_nxt,
  output logic          qbit
);

  logic [SW+1:0] shifted;
  logic [SW+1:0] trial;

  // shifted < 2^(SW+1) and dvs_mag < 2^SW, so the difference always fits in
  // SW+2 bits two's complement and its MSB is a reliable sign.
  always_comb begin
    shifted = {pr, din};
    trial   = shifted - {2'b00, dvs_mag};
    qbit    = ~trial[SW+1];
    pr_nxt  = qbit ? trial[SW:0] : shifted[SW:0];
  end

endmodule

// File: rtl/si_div_16b_seq.sv
// si_div_16b_seq: iterative signed divider, radix-2 restoring, one quotient
// bit per clock. Truncates toward zero; remainder takes the dividend's sign.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_vld/in_rdy   : operand handshake (dvd DW-bit, dvs SW-bit, signed)
//   out_vld/out_rdy : result handshake (quo DW-bit, rem SW-bit, signed)
//   dz              : divide-by-zero (quo saturated by dividend sign, rem 0)
//   ovf             : -2^(DW-1) / -1 (quo saturated positive, rem 0)
module si_div_16b_seq
  import si_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] dvd,
  input  logic [SW-1:0] dvs,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] quo,
  output logic [SW-1:0] rem,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] Q_POS_SAT = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_NEG_SAT = {1'b1, {(DW-1){1'b0}}};

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [DW-1:0] a_mag;     // dividend magnitude; quotient bits shift in at the LSB
  logic [SW-1:0] b_mag;     // divisor magnitude
  logic [SW:0]   pr;        // partial remainder magnitude
  logic          sign_q;
  logic          sign_r;

  logic          accept;
  logic          last;
  logic          dvs_zero;
  logic [DW-1:0] dvd_abs;
  logic [SW-1:0] dvs_abs;
  logic [SW:0]   pr_nxt;
  logic          qbit;
  logic [DW-1:0] q_mag;
  logic [SW-1:0] r_mag;
  logic [DW-1:0] quo_fin;
  logic [SW-1:0] rem_fin;
  logic          ovf_fin;

  si_div_step #(.SW(SW)) u_step (
    .pr      (pr),
    .din     (a_mag[DW-1]),
    .dvs_mag (b_mag),
    .pr_nxt  (pr_nxt),
    .qbit    (qbit)
  );

  // FSM state register.
  // NOTE: async active-low reset; all sequential state uses non-blocking (<=)
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = dvs_zero ? DONE : CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes (|-2^(DW-1)| wraps to 2^(DW-1), which is correct
  // when read as unsigned) and final sign correction.
  always_comb begin
    accept   = in_rdy & in_vld;
    last     = (state == CALC) && (cnt == CW'(DW - 1));
    dvs_zero = (dvs == '0);
    dvd_abs  = dvd[DW-1] ? -dvd : dvd;
    dvs_abs  = dvs[SW-1] ? -dvs : dvs;

    q_mag    = {a_mag[DW-2:0], qbit};
    r_mag    = pr_nxt[SW-1:0];
    // A magnitude of 2^(DW-1) with a positive sign only arises from
    // -2^(DW-1) / -1; a negative sign maps it back to -2^(DW-1) exactly.
    ovf_fin  = q_mag[DW-1] & ~sign_q;
    quo_fin  = ovf_fin ? Q_POS_SAT : (sign_q ? -q_mag : q_mag);
    rem_fin  = ovf_fin ? '0 : (sign_r ? -r_mag : r_mag);
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      pr     <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_mag  <= dvd_abs;
      b_mag  <= dvs_abs;
      pr     <= '0;
      sign_q <= dvd[DW-1] ^ dvs[SW-1];
      sign_r <= dvd[DW-1];
      dz     <= dvs_zero;
      ovf    <= 1'b0;
      if (dvs_zero) begin
        quo <= dvd[DW-1] ? Q_NEG_SAT : Q_POS_SAT;
        rem <= '0;
      end
    end else if (state == CALC) begin
      cnt   <= cnt + 1'b1;
      a_mag <= q_mag;
      pr    <= pr_nxt;
      if (last) begin
        quo <= quo_fin;
        rem <= rem_fin;
        ovf <= ovf_fin;
      end
    end
  end

endmodule

// File: tb/tb_si_div_16b_seq.sv
// tb_si_div_16b_seq: self-checking bench for si_div_16b_seq.
// Directed cases, backpressure, reset mid-operation and randomized operands
// compared against an integer-arithmetic reference model.
module tb_si_div_16b_seq;
  import si_div_pkg::*;

  localparam int DW = DW_DEF;
  localparam int SW = SW_DEF;
  localparam int N_RAND = 3000;

  logic          clk;
  logic          rst_n;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] dvd;
  logic [SW-1:0] dvs;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] quo;
  logic [SW-1:0] rem;
  logic          dz;
  logic          ovf;

  int n_chk  = 0;
  int n_fail = 0;

  si_div_16b_seq #(.DW(DW), .SW(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .dvd     (dvd),
    .dvs     (dvs),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .quo     (quo),
    .rem     (rem),
    .dz      (dz),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder
  // follows the dividend), plus the two saturating special cases.
  task automatic ref_div(input int a, input int b,
                         output logic [DW-1:0] q, output logic [SW-1:0] r,
                         output logic z, output logic o);
    int qi, ri;
    z = 1'b0;
    o = 1'b0;
    if (b == 0) begin
      z  = 1'b1;
      qi = (a >= 0) ? 32767 : -32768;
      ri = 0;
    end else if (a == -32768 && b == -1) begin
      o  = 1'b1;
      qi = 32767;
      ri = 0;
    end else begin
      qi = a / b;
      ri = a % b;
    end
    q = qi[DW-1:0];
    r = ri[SW-1:0];
  endtask

  // One full transaction: accept, wait for result, compare, drain.
  task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input string tag,
                        output logic [DW-1:0] q_got, output logic [SW-1:0] r_got);
    logic [DW-1:0] eq;
    logic [SW-1:0] er;
    logic          ez, eo;
    int            w;
    int            lat;
    w = 0;
    while (!in_rdy && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    dvd    = a;
    dvs    = b;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 2 * DW + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    ref_div(int'($signed(a)), int'($signed(b)), eq, er, ez, eo);
    check({tag, ".vld"}, 32'(out_vld), 32'd1);
    // Edges after the accepting edge until out_vld: DW normally, none for dz.
    check({tag, ".lat"}, lat, (b == '0) ? 0 : DW);
    check({tag, ".quo"}, 32'(quo), 32'(eq));
    check({tag, ".rem"}, 32'(rem), 32'(er));
    check({tag, ".dz"},  32'(dz),  32'(ez));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    q_got = quo;
    r_got = rem;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check({tag, ".ret"}, {30'd0, in_rdy, out_vld}, 32'b10);
  endtask

  initial begin
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic [DW-1:0] ra;
    logic [SW-1:0] rb;
    int            wv;

    rst_n   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    dvd     = '0;
    dvs     = '0;
    #12;
    check("rst.in_rdy",  32'(in_rdy),  32'd1);
    check("rst.out_vld", 32'(out_vld), 32'd0);
    check("rst.quo",     32'(quo),     32'd0);
    check("rst.rem",     32'(rem),     32'd0);
    check("rst.flags",   {30'd0, dz, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the plan, with explicit expected bit patterns.
    run_op(16'd100, 8'd7, "p100_7", q, r);
    check("p100_7.q_lit", 32'(q), 32'h000E);
    check("p100_7.r_lit", 32'(r), 32'h02);
    run_op(-16'sd100, 8'd7, "n100_7", q, r);
    check("n100_7.q_lit", 32'(q), 32'hFFF2);
    check("n100_7.r_lit", 32'(r), 32'hFE);
    run_op(16'd100, -8'sd7, "p100_n7", q, r);
    check("p100_n7.q_lit", 32'(q), 32'hFFF2);
    check("p100_n7.r_lit", 32'(r), 32'h02);
    run_op(16'h8000, 8'h80, "min_min", q, r);
    check("min_min.q_lit", 32'(q), 32'h0100);
    run_op(16'h8000, 8'hFF, "ovf", q, r);
    check("ovf.q_lit", {16'd0, q}, 32'h7FFF);
    check("ovf.flag", 32'(ovf), 32'd1);
    run_op(-16'sd5, 8'd0, "dz_neg", q, r);
    check("dz_neg.q_lit", 32'(q), 32'h8000);
    run_op(16'd1234, 8'd0, "dz_pos", q, r);
    check("dz_pos.q_lit", 32'(q), 32'h7FFF);
    run_op(16'h8000, 8'd1, "min_1", q, r);

    // Backpressure: result held, new operands ignored while out_rdy is low.
    dvd    = 16'd100;
    dvs    = 8'd7;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    wv = 0;
    while (!out_vld && wv < 2 * DW + 8) begin
      @(posedge clk); #1;
      wv++;
    end
    check("bp.vld", 32'(out_vld), 32'd1);
    dvd    = 16'hFFFF;
    dvs    = 8'd3;
    in_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.hold_vld", {30'd0, out_vld, in_rdy}, 32'b10);
      check("bp.hold_quo", 32'(quo), 32'h000E);
      check("bp.hold_rem", 32'(rem), 32'h02);
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check("bp.release", {30'd0, in_rdy, out_vld}, 32'b10);
    @(posedge clk); #1;
    check("bp.idle", {30'd0, in_rdy, out_vld}, 32'b10);

    // Reset in the middle of CALC.
    dvd    = 16'd100;
    dvs    = 8'd7;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rmid.busy", 32'(in_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rmid.rdy_vld", {30'd0, in_rdy, out_vld}, 32'b10);
    check("rmid.quo", 32'(quo), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rmid.no_out", 32'(out_vld), 32'd0);
    run_op(16'd100, 8'd7, "rmid_run", q, r);

    // Randomized operands, biased towards the boundary values.
    for (int i = 0; i < N_RAND; i++) begin
      ra = DW'($urandom);
      rb = SW'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: ra = 16'h8000;
        2: rb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h01;
        3: begin ra = 16'h8000; rb = 8'hFF; end
        4: rb = 8'h80;
        default: ;
      endcase
      run_op(ra, rb, "rand", q, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
